// File: rtl/win_scan_seq_if.sv
// ---------------------------------------------------------------------------
// win_scan_seq_if
// Request/result bundle between the move-commit logic (master) and the
// sequential win detector (slave).
//
// Signals
//   start            master->slave  one-cycle scan request
//   player           master->slave  player who just moved
//   location         master->slave  column of the placed piece (0 = leftmost)
//   height           master->slave  row of the placed piece (0 = bottom)
//   player_register  master->slave  owner bit per cell, index ROWS*col+row
//   onoff_register   master->slave  occupancy bit per cell, same index
//   busy             slave->master  scan in progress
//   done             slave->master  one-cycle result-valid pulse
//   win              slave->master  winning run through the origin found
//   win_dir          slave->master  0 vert, 1 horiz, 2 diag, 3 anti-diag
//   range_err        slave->master  origin was off the board
// ---------------------------------------------------------------------------
interface win_scan_seq_if #(
  parameter int COLS = 7,
  parameter int ROWS = 6
);
  localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int N  = COLS * ROWS;

  logic          start;
  logic          player;
  logic [CW-1:0] location;
  logic [RW-1:0] height;
  logic [N-1:0]  player_register;
  logic [N-1:0]  onoff_register;
  logic          busy;
  logic          done;
  logic          win;
  logic [1:0]    win_dir;
  logic          range_err;

  modport master (
    output start, player, location, height, player_register, onoff_register,
    input  busy, done, win, win_dir, range_err
  );

  modport slave (
    input  start, player, location, height, player_register, onoff_register,
    output busy, done, win, win_dir, range_err
  );
endinterface

// File: rtl/win_scan_seq.sv
// ---------------------------------------------------------------------------
// win_scan_seq
// Sequential Connect-Four win detector. On an accepted start it snapshots
// both board registers and the placed piece, then walks outward from that
// piece along the vertical, horizontal, diagonal and anti-diagonal lines,
// one cell per clock (positive ray first, then negative ray), and reports
// win / no-win plus the winning direction with a one-cycle done pulse.
//
// Parameters
//   COLS, ROWS  board size
//   WIN_LEN     run length that wins (2..max(COLS,ROWS))
//
// Ports
//   clock       rising-edge clock
//   reset       synchronous, active-high
//   bus         win_scan_seq_if.slave (request inputs, result outputs)
// ---------------------------------------------------------------------------
module win_scan_seq #(
  parameter int COLS    = 7,
  parameter int ROWS    = 6,
  parameter int WIN_LEN = 4
) (
  input  logic           clock,
  input  logic           reset,
  win_scan_seq_if.slave  bus
);

  localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int N  = COLS * ROWS;
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam int KW = $clog2(WIN_LEN + 1);
  localparam int MW = (CW > RW) ? CW : RW;
  // Signed coordinate width: wide enough for origin +/- (WIN_LEN-1), so a
  // step past any edge shows up as out of range instead of wrapping.
  localparam int AW = ((MW > KW) ? MW : KW) + 2;

  localparam logic signed [AW-1:0] COLS_S = AW'(COLS);
  localparam logic signed [AW-1:0] ROWS_S = AW'(ROWS);
  localparam logic [IW-1:0]        ROWS_I = IW'(ROWS);
  localparam logic [KW-1:0]        WIN_K  = KW'(WIN_LEN);
  localparam logic [KW-1:0]        ONE_K  = KW'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  // Control state
  state_t        state_q, state_d;
  logic [1:0]    dir_q, dir_d;
  logic          neg_q, neg_d;      // 0: positive ray, 1: negative ray
  logic [KW-1:0] k_q, k_d;          // step along the current ray
  logic [KW-1:0] cnt_q, cnt_d;      // run length so far, origin included
  logic          win_q, win_d;
  logic [1:0]    win_dir_q, win_dir_d;
  logic          range_err_q, range_err_d;

  // Snapshot taken when a start is accepted
  logic                 player_q;
  logic signed [AW-1:0] col0_q, row0_q;
  logic [N-1:0]         preg_q, oreg_q;
  logic                 snap;

  // Cell under examination
  logic signed [AW-1:0] loc_in, hgt_in;
  logic signed [AW-1:0] step_s, col_s, row_s;
  logic                 in_bounds;
  logic [IW-1:0]        idx;
  logic                 cell_match;
  logic                 end_ray;

  assign loc_in = $signed(AW'(bus.location));
  assign hgt_in = $signed(AW'(bus.height));

  // Address of the cell at origin + s*k*(dc,dr)
  always_comb begin
    step_s = $signed(AW'(k_q));
    if (neg_q) begin
      step_s = -step_s;
    end
    col_s = col0_q;
    row_s = row0_q;
    case (dir_q)
      2'd0: row_s = row0_q + step_s;
      2'd1: col_s = col0_q + step_s;
      2'd2: begin
        col_s = col0_q + step_s;
        row_s = row0_q + step_s;
      end
      default: begin
        col_s = col0_q + step_s;
        row_s = row0_q - step_s;
      end
    endcase
    in_bounds = !col_s[AW-1] && (col_s < COLS_S) &&
                !row_s[AW-1] && (row_s < ROWS_S);
    // Modular IW-bit arithmetic is exact for every in-bounds cell
    idx        = IW'(col_s) * ROWS_I + IW'(row_s);
    // An empty cell never matches, whatever its owner bit says
    cell_match = in_bounds && oreg_q[idx] && (preg_q[idx] == player_q);
  end

  // Next-state and result logic
  always_comb begin
    state_d     = state_q;
    dir_d       = dir_q;
    neg_d       = neg_q;
    k_d         = k_q;
    cnt_d       = cnt_q;
    win_d       = win_q;
    win_dir_d   = win_dir_q;
    range_err_d = range_err_q;
    snap        = 1'b0;
    end_ray     = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          snap      = 1'b1;
          win_d     = 1'b0;
          win_dir_d = 2'd0;
          if ((loc_in >= COLS_S) || (hgt_in >= ROWS_S)) begin
            range_err_d = 1'b1;
            state_d     = DONE;
          end else begin
            range_err_d = 1'b0;
            dir_d       = 2'd0;
            neg_d       = 1'b0;
            k_d         = ONE_K;
            cnt_d       = ONE_K;
            state_d     = SCAN;
          end
        end
      end

      SCAN: begin
        if (cell_match) begin
          cnt_d = cnt_q + 1'b1;
          k_d   = k_q + 1'b1;
          if (cnt_q + 1'b1 == WIN_K) begin
            win_d     = 1'b1;
            win_dir_d = dir_q;
            state_d   = DONE;
          end else if (k_q + 1'b1 == WIN_K) begin
            end_ray = 1'b1;
          end
        end else begin
          end_ray = 1'b1;
        end

        // Positive ray hands over to the negative ray keeping the count;
        // the negative ray closes the direction and restarts the count.
        if (end_ray) begin
          if (!neg_q) begin
            neg_d = 1'b1;
            k_d   = ONE_K;
          end else if (dir_q == 2'd3) begin
            state_d = DONE;
          end else begin
            dir_d = dir_q + 2'd1;
            neg_d = 1'b0;
            k_d   = ONE_K;
            cnt_d = ONE_K;
          end
        end
      end

      DONE: state_d = IDLE;

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      dir_q       <= 2'd0;
      neg_q       <= 1'b0;
      k_q         <= ONE_K;
      cnt_q       <= ONE_K;
      win_q       <= 1'b0;
      win_dir_q   <= 2'd0;
      range_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      dir_q       <= dir_d;
      neg_q       <= neg_d;
      k_q         <= k_d;
      cnt_q       <= cnt_d;
      win_q       <= win_d;
      win_dir_q   <= win_dir_d;
      range_err_q <= range_err_d;
    end
  end

  // Snapshot registers carry data only; they need no reset because nothing
  // reads them outside SCAN, which is only entered after a snapshot.
  always_ff @(posedge clock) begin
    if (snap) begin
      player_q <= bus.player;
      col0_q   <= loc_in;
      row0_q   <= hgt_in;
      preg_q   <= bus.player_register;
      oreg_q   <= bus.onoff_register;
    end
  end

  assign bus.busy      = (state_q != IDLE);
  assign bus.done      = (state_q == DONE);
  assign bus.win       = win_q;
  assign bus.win_dir   = win_dir_q;
  assign bus.range_err = range_err_q;

endmodule

// File: tb/tb_win_scan_seq.sv
// ---------------------------------------------------------------------------
// tb_win_scan_seq
// Bench for win_scan_seq: a default 7x6/4 instance and a 9x8/5 instance
// share one clock and reset. Directed cases plus randomized boards checked
// against a run-length reference model of the scan.
// ---------------------------------------------------------------------------
module tb_win_scan_seq;
  localparam int C0 = 7, R0 = 6, W0 = 4, CW0 = 3, RW0 = 3;
  localparam int C1 = 9, R1 = 8, W1 = 5, CW1 = 4, RW1 = 3;
  localparam int MAXC = 9, MAXR = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  win_scan_seq_if #(.COLS(C0), .ROWS(R0)) bus0();
  win_scan_seq_if #(.COLS(C1), .ROWS(R1)) bus1();

  win_scan_seq #(.COLS(C0), .ROWS(R0), .WIN_LEN(W0)) dut0 (
    .clock(clk), .reset(rst), .bus(bus0.slave)
  );
  win_scan_seq #(.COLS(C1), .ROWS(R1), .WIN_LEN(W1)) dut1 (
    .clock(clk), .reset(rst), .bus(bus1.slave)
  );

  int n_checks = 0;
  int n_errors = 0;
  bit occ [MAXC][MAXR];
  bit own [MAXC][MAXR];
  int sel, cols, rows, wl, cw, rw;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic use_inst(input int s);
    sel = s;
    if (s == 0) begin cols = C0; rows = R0; wl = W0; cw = CW0; rw = RW0; end
    else        begin cols = C1; rows = R1; wl = W1; cw = CW1; rw = RW1; end
  endtask

  task automatic clear_board();
    for (int c = 0; c < MAXC; c++)
      for (int r = 0; r < MAXR; r++) begin
        occ[c][r] = 1'b0;
        own[c][r] = 1'b0;
      end
  endtask

  task automatic put(input int c, input int r, input bit p);
    occ[c][r] = 1'b1;
    own[c][r] = p;
  endtask

  function automatic bit cell_ok(input int c, input int r, input bit pl);
    if (c < 0 || c >= cols || r < 0 || r >= rows) return 1'b0;
    return occ[c][r] && (own[c][r] == pl);
  endfunction

  // Reference: count the matching run on each side of the origin per
  // direction; the scan stops at the cell that completes WIN_LEN.
  function automatic void model(input bit pl, input int loc, input int hgt,
                                output bit w, output int dir, output int l,
                                output bit re);
    int dc, dr, pos, neg;
    w = 1'b0; dir = 0; l = 0; re = 1'b0;
    if (loc >= cols || hgt >= rows) begin
      re = 1'b1;
      return;
    end
    for (int d = 0; d < 4; d++) begin
      dc = (d == 0) ? 0 : 1;
      dr = (d == 1) ? 0 : ((d == 3) ? -1 : 1);
      pos = 0;
      while (pos < wl - 1 && cell_ok(loc + (pos + 1) * dc, hgt + (pos + 1) * dr, pl)) pos++;
      if (pos == wl - 1) begin
        l += pos; w = 1'b1; dir = d;
        return;
      end
      l += pos + 1;
      neg = 0;
      while (neg < wl - 1 && cell_ok(loc - (neg + 1) * dc, hgt - (neg + 1) * dr, pl)) neg++;
      if (1 + pos + neg >= wl) begin
        l += wl - 1 - pos; w = 1'b1; dir = d;
        return;
      end
      l += neg + 1;
    end
  endfunction

  task automatic drive_inputs(input bit pl, input int loc, input int hgt);
    logic [MAXC*MAXR-1:0] vp, vo;
    vp = '0;
    vo = '0;
    for (int c = 0; c < cols; c++)
      for (int r = 0; r < rows; r++) begin
        vp[rows*c+r] = own[c][r];
        vo[rows*c+r] = occ[c][r];
      end
    if (sel == 0) begin
      bus0.player = pl; bus0.location = CW0'(loc); bus0.height = RW0'(hgt);
      bus0.player_register = vp[C0*R0-1:0]; bus0.onoff_register = vo[C0*R0-1:0];
    end else begin
      bus1.player = pl; bus1.location = CW1'(loc); bus1.height = RW1'(hgt);
      bus1.player_register = vp[C1*R1-1:0]; bus1.onoff_register = vo[C1*R1-1:0];
    end
  endtask

  // Full board owned by player 1, origin at the corner: would win at once
  task automatic drive_scramble();
    if (sel == 0) begin
      bus0.player = 1'b1; bus0.location = '0; bus0.height = '0;
      bus0.player_register = '1; bus0.onoff_register = '1;
    end else begin
      bus1.player = 1'b1; bus1.location = '0; bus1.height = '0;
      bus1.player_register = '1; bus1.onoff_register = '1;
    end
  endtask

  task automatic set_start(input bit v);
    if (sel == 0) bus0.start = v;
    else          bus1.start = v;
  endtask

  task automatic sample(output logic b, output logic d, output logic w,
                        output logic [1:0] wd, output logic re);
    if (sel == 0) begin
      b = bus0.busy; d = bus0.done; w = bus0.win; wd = bus0.win_dir; re = bus0.range_err;
    end else begin
      b = bus1.busy; d = bus1.done; w = bus1.win; wd = bus1.win_dir; re = bus1.range_err;
    end
  endtask

  // Issue one request and wait (bounded) for done. scans = SCAN cycles seen.
  task automatic run_scan(input string tag, input bit pl, input int loc, input int hgt,
                          input int restart_at, input int watch,
                          output logic w, output logic [1:0] wd, output logic re,
                          output int scans);
    int lat, extra;
    bit seen;
    logic b, d, ww, rr;
    logic [1:0] dd;
    @(negedge clk);
    drive_inputs(pl, loc, hgt);
    set_start(1'b1);
    lat = 0; seen = 1'b0; scans = -1; w = 1'b0; wd = 2'd0; re = 1'b0;
    while (!seen && lat < 100) begin
      @(negedge clk);
      lat++;
      set_start(1'b0);
      if (lat == restart_at) begin
        drive_scramble();
        set_start(1'b1);
      end
      sample(b, d, ww, dd, rr);
      if (lat == 1) check({tag, "/busy_on"}, {31'd0, b}, 1);
      if (d) begin
        seen = 1'b1; scans = lat - 1; w = ww; wd = dd; re = rr;
      end
    end
    set_start(1'b0);
    if (!seen) check({tag, "/timeout"}, 0, 1);
    @(negedge clk);
    sample(b, d, ww, dd, rr);
    check({tag, "/busy_off"}, {31'd0, b}, 0);
    check({tag, "/done_pulse"}, {31'd0, d}, 0);
    extra = 0;
    repeat (watch) begin
      @(negedge clk);
      sample(b, d, ww, dd, rr);
      if (d) extra++;
    end
    check({tag, "/extra_done"}, extra, 0);
  endtask

  task automatic run_expect(input string tag, input bit pl, input int loc, input int hgt,
                            input int e_scans, input bit e_win, input int e_dir, input bit e_re);
    logic w, re;
    logic [1:0] wd;
    int sc;
    run_scan(tag, pl, loc, hgt, -1, 2, w, wd, re, sc);
    check({tag, "/scans"}, sc, e_scans);
    check({tag, "/win"}, {31'd0, w}, {31'd0, e_win});
    check({tag, "/range_err"}, {31'd0, re}, {31'd0, e_re});
    if (!e_re) check({tag, "/win_dir"}, {30'd0, wd}, e_dir);
  endtask

  task automatic random_runs(input int n);
    int dens, bias, loc, hgt, e_dir, e_l, sc;
    bit pl, e_w, e_re;
    logic w, re;
    logic [1:0] wd;
    for (int it = 0; it < n; it++) begin
      clear_board();
      dens = $urandom_range(30, 95);
      bias = $urandom_range(40, 92);
      pl = 1'($urandom_range(0, 1));
      for (int c = 0; c < cols; c++)
        for (int r = 0; r < rows; r++) begin
          occ[c][r] = ($urandom_range(0, 99) < dens);
          own[c][r] = ($urandom_range(0, 99) < bias) ? pl : ~pl;
        end
      loc = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, (1 << cw) - 1))
                                        : int'($urandom_range(0, cols - 1));
      hgt = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, (1 << rw) - 1))
                                        : int'($urandom_range(0, rows - 1));
      model(pl, loc, hgt, e_w, e_dir, e_l, e_re);
      run_scan("rand", pl, loc, hgt, -1, 1, w, wd, re, sc);
      check("rand/range_err", {31'd0, re}, {31'd0, e_re});
      check("rand/win", {31'd0, w}, {31'd0, e_w});
      if (!e_re) begin
        check("rand/scans", sc, e_l);
        check("rand/win_dir", {30'd0, wd}, e_w ? e_dir : 0);
      end
    end
  endtask

  initial begin
    logic w, re, b, d;
    logic [1:0] wd;
    int sc, e_dir, e_l;
    bit e_w, e_re;

    rst = 1'b1;
    use_inst(1); clear_board(); drive_inputs(1'b0, 0, 0); set_start(1'b0);
    use_inst(0); clear_board(); drive_inputs(1'b0, 0, 0); set_start(1'b0);
    repeat (3) @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      use_inst(s);
      sample(b, d, w, wd, re);
      check("reset/busy", {31'd0, b}, 0);
      check("reset/done", {31'd0, d}, 0);
      check("reset/win", {31'd0, w}, 0);
      check("reset/win_dir", {30'd0, wd}, 0);
      check("reset/range_err", {31'd0, re}, 0);
    end
    rst = 1'b0;

    // ---- default 7x6, WIN_LEN 4 ----
    use_inst(0);
    clear_board(); put(3, 0, 1'b1);
    run_expect("empty", 1'b1, 3, 0, 8, 1'b0, 0, 1'b0);

    clear_board();
    for (int r = 0; r < 4; r++) put(2, r, 1'b1);
    run_expect("vert", 1'b1, 2, 3, 4, 1'b1, 0, 1'b0);
    repeat (4) @(negedge clk);
    sample(b, d, w, wd, re);
    check("vert/hold_win", {31'd0, w}, 1);
    check("vert/hold_dir", {30'd0, wd}, 0);

    clear_board();
    put(1, 0, 1'b0); put(2, 0, 1'b0); put(3, 0, 1'b0); put(4, 0, 1'b0);
    run_expect("horiz", 1'b0, 3, 0, 6, 1'b1, 1, 1'b0);

    clear_board();
    put(0, 0, 1'b1); put(1, 1, 1'b1); put(2, 2, 1'b0); put(3, 3, 1'b1);
    run_expect("diag_opp", 1'b1, 3, 3, 8, 1'b0, 0, 1'b0);
    occ[2][2] = 1'b0; own[2][2] = 1'b1;
    run_expect("diag_empty", 1'b1, 3, 3, 8, 1'b0, 0, 1'b0);

    run_expect("range_col", 1'b1, 7, 0, 0, 1'b0, 0, 1'b1);
    run_expect("range_row", 1'b0, 0, 6, 0, 1'b0, 0, 1'b1);
    repeat (3) @(negedge clk);
    sample(b, d, w, wd, re);
    check("range/hold", {31'd0, re}, 1);

    // Second start (with different inputs) mid-scan must be dropped
    clear_board(); put(3, 0, 1'b1);
    run_scan("restart", 1'b1, 3, 0, 3, 30, w, wd, re, sc);
    check("restart/scans", sc, 8);
    check("restart/win", {31'd0, w}, 0);
    check("restart/range_err", {31'd0, re}, 0);

    // Reset three cycles into a scan
    clear_board(); put(3, 0, 1'b1);
    @(negedge clk);
    drive_inputs(1'b1, 3, 0);
    set_start(1'b1);
    @(negedge clk);
    set_start(1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    sample(b, d, w, wd, re);
    check("rstmid/busy", {31'd0, b}, 0);
    check("rstmid/done", {31'd0, d}, 0);
    check("rstmid/win", {31'd0, w}, 0);
    begin
      int dn;
      dn = 0;
      repeat (12) begin
        @(negedge clk);
        sample(b, d, w, wd, re);
        if (d) dn++;
      end
      check("rstmid/no_done", dn, 0);
    end

    // ---- 9x8, WIN_LEN 5 ----
    use_inst(1);
    clear_board();
    put(2, 6, 1'b1); put(3, 5, 1'b1); put(4, 4, 1'b1); put(5, 3, 1'b1); put(6, 2, 1'b1);
    run_expect("anti5", 1'b1, 4, 4, 11, 1'b1, 3, 1'b0);
    occ[6][2] = 1'b0;
    run_expect("anti4", 1'b1, 4, 4, 11, 1'b0, 0, 1'b0);
    model(1'b1, 4, 4, e_w, e_dir, e_l, e_re);
    check("anti4/model_scans", e_l, 11);

    // ---- randomized boards on both builds ----
    use_inst(0);
    random_runs(150);
    use_inst(1);
    random_runs(150);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
